sm3_expnd_core: RTL and testbench

SM3 message expansion stage, directly downstream of `sm3_pad_core`. It accepts the padded 512-bit blocks that `sm3_pad_core` emits on its output word bus and buffers each block in a 16-word sliding window. From that window it generates the 64 round word pairs W_j and W'_j (j = 0..63), one pair per cycle, for the compression stage. It also marks the final round of the final block of a message.

---
 rtl/sm3_expnd_core_pkg.sv | 24 ++
 rtl/sm3_expnd_core_if.sv | 25 ++
 rtl/sm3_expnd_core_w_gen.sv | 15 +
 rtl/sm3_expnd_core.sv | 136 +++++++++++++
 tb/tb_sm3_expnd_core.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_expnd_core_pkg.sv
// Shared SM3 constants, word type, expansion FSM states and the ROTL/P1 helpers.
package sm3_expnd_core_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int ROUNDS    = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EXPND = 2'd2
  } expnd_st_e;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  function automatic word_t p1(input word_t x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

endpackage

// File: rtl/sm3_expnd_core_if.sv
// Pad-output word channel (upstream) and W_j/W'_j round-word channel (downstream).
interface sm3_expnd_core_if #(parameter int INPT_DW = 32);

  logic [INPT_DW-1:0] pad_otpt_d;
  logic               pad_otpt_vld;
  logic               pad_otpt_lst;
  logic               pad_otpt_ena;

  logic [31:0]        expnd_wj;
  logic [31:0]        expnd_wjj;
  logic               expnd_vld;
  logic               expnd_lst;
  logic               expnd_rdy;

  modport master (
    output pad_otpt_d, pad_otpt_vld, pad_otpt_lst, expnd_rdy,
    input  pad_otpt_ena, expnd_wj, expnd_wjj, expnd_vld, expnd_lst
  );

  modport slave (
    input  pad_otpt_d, pad_otpt_vld, pad_otpt_lst, expnd_rdy,
    output pad_otpt_ena, expnd_wj, expnd_wjj, expnd_vld, expnd_lst
  );

endinterface

// File: rtl/sm3_expnd_core_w_gen.sv
// Combinational SM3 expansion step: produces W_{j+16} from five window taps.
module sm3_expnd_w_gen
  import sm3_expnd_core_pkg::*;
(
  input  word_t w0,
  input  word_t w3,
  input  word_t w7,
  input  word_t w10,
  input  word_t w13,
  output word_t w16
);

  assign w16 = p1(w0 ^ w7 ^ rotl(w13, 15)) ^ rotl(w3, 7) ^ w10;

endmodule

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: buffers a padded block in a 16-word window and emits W_j/W'_j.
// Optional output register stage selected by defining SM3_EXPND_OTPT_REG_EN.
//
// state    | meaning
// ST_IDLE  | waiting for the first beat of a block, ena high
// ST_LOAD  | shifting beats into the window until the block is complete
// ST_EXPND | emitting W_j/W'_j for j = 0..63, ena low
module sm3_expnd_core
  import sm3_expnd_core_pkg::*;
#(
  parameter int INPT_DW = 32
) (
  input logic             clk,
  input logic             rst_n,
  sm3_expnd_core_if.slave bus
);

  localparam int WPB   = INPT_DW / WORD_W;
  localparam int BEATS = BLK_WORDS / WPB;
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  expnd_st_e  state, state_nxt;
  word_t      win [BLK_WORDS];
  logic [3:0] beat_cnt;
  logic [5:0] j_cnt;
  logic       blk_lst;

  logic  pad_ena, acc, last_beat, last_rnd;
  logic  core_vld, core_rdy, core_hs, core_lst;
  word_t core_wj, core_wjj, w_new;

  assign acc       = bus.pad_otpt_vld & pad_ena;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign last_rnd  = (j_cnt == 6'd63);
  assign core_hs   = core_vld & core_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_LOAD: if (acc) state_nxt = last_beat ? ST_EXPND : ST_LOAD;
      ST_EXPND:         if (core_hs && last_rnd) state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pad_ena  = 1'b1;
    core_vld = 1'b0;
    if (state == ST_EXPND) begin
      pad_ena  = 1'b0;
      core_vld = 1'b1;
    end
  end

  sm3_expnd_w_gen u_w_gen (
    .w0  (win[0]),
    .w3  (win[3]),
    .w7  (win[7]),
    .w10 (win[10]),
    .w13 (win[13]),
    .w16 (w_new)
  );

  // Earlier words enter at the high slots so the first word ends up in slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_WORDS; i++) win[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < BLK_WORDS - WPB; i++) win[i] <= win[i+WPB];
      for (int k = 0; k < WPB; k++)
        win[BLK_WORDS-WPB+k] <= bus.pad_otpt_d[INPT_DW-1-WORD_W*k -: WORD_W];
    end else if (core_hs) begin
      for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
      win[BLK_WORDS-1] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      j_cnt    <= '0;
      blk_lst  <= 1'b0;
    end else begin
      if (acc) beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
      if (core_hs) j_cnt <= j_cnt + 6'd1;
      if (acc && last_beat)          blk_lst <= bus.pad_otpt_lst;
      else if (core_hs && last_rnd)  blk_lst <= 1'b0;
    end
  end

  assign core_wj  = win[0];
  assign core_wjj = win[0] ^ win[4];
  assign core_lst = blk_lst & last_rnd & core_vld;
  assign bus.pad_otpt_ena = pad_ena;

`ifdef SM3_EXPND_OTPT_REG_EN
  logic  o_vld, o_lst;
  word_t o_wj, o_wjj;

  // Register refills whenever it is empty or being drained, so stalls lose nothing.
  assign core_rdy = ~o_vld | bus.expnd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld <= 1'b0;
      o_lst <= 1'b0;
      o_wj  <= '0;
      o_wjj <= '0;
    end else if (core_rdy) begin
      o_vld <= core_vld;
      o_lst <= core_lst;
      if (core_vld) begin
        o_wj  <= core_wj;
        o_wjj <= core_wjj;
      end
    end
  end

  assign bus.expnd_vld = o_vld;
  assign bus.expnd_lst = o_lst;
  assign bus.expnd_wj  = o_wj;
  assign bus.expnd_wjj = o_wjj;
`else
  assign core_rdy      = bus.expnd_rdy;
  assign bus.expnd_vld = core_vld;
  assign bus.expnd_lst = core_lst;
  assign bus.expnd_wj  = core_wj;
  assign bus.expnd_wjj = core_wjj;
`endif

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Directed bench for sm3_expnd_core at 32- and 64-bit input width.
module tb_sm3_expnd_core;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] wv_t  [64];
  typedef logic [31:0] wx_t  [68];

`ifdef SM3_EXPND_OTPT_REG_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm3_expnd_core_if #(.INPT_DW(32)) bus32();
  sm3_expnd_core_if #(.INPT_DW(64)) bus64();

  sm3_expnd_core #(.INPT_DW(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  sm3_expnd_core #(.INPT_DW(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

  int checks = 0;
  int failures = 0;

  blk_t abc, blk2;
  wv_t  ow, owjj;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_p1(input logic [31:0] x);
    return x ^ m_rotl(x, 15) ^ m_rotl(x, 23);
  endfunction

  task automatic expand(input blk_t b, output wx_t w);
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int j = 16; j < 68; j++)
      w[j] = m_p1(w[j-16] ^ w[j-9] ^ m_rotl(w[j-3], 15)) ^ m_rotl(w[j-13], 7) ^ w[j-6];
  endtask

  task automatic idle_inputs();
    bus32.pad_otpt_d = '0; bus32.pad_otpt_vld = 1'b0; bus32.pad_otpt_lst = 1'b0;
    bus64.pad_otpt_d = '0; bus64.pad_otpt_vld = 1'b0; bus64.pad_otpt_lst = 1'b0;
  endtask

  task automatic chk_rst(input bit sel);
    if (sel) begin
      chk("rst_ena64", bus64.pad_otpt_ena, 1);
      chk("rst_vld64", bus64.expnd_vld, 0);
      chk("rst_lst64", bus64.expnd_lst, 0);
      chk("rst_wj64",  bus64.expnd_wj, 0);
      chk("rst_wjj64", bus64.expnd_wjj, 0);
    end else begin
      chk("rst_ena32", bus32.pad_otpt_ena, 1);
      chk("rst_vld32", bus32.expnd_vld, 0);
      chk("rst_lst32", bus32.expnd_lst, 0);
      chk("rst_wj32",  bus32.expnd_wj, 0);
      chk("rst_wjj32", bus32.expnd_wjj, 0);
    end
  endtask

  // Sends the first nbeats beats of a block; returns 1 time unit after the last accepting edge.
  task automatic send(input bit sel, input blk_t b, input bit lst, input int nbeats);
    int nb;
    int guard;
    nb = sel ? 8 : 16;
    for (int k = 0; k < nbeats; k++) begin
      if (sel) begin
        bus64.pad_otpt_d   = {b[2*k], b[2*k+1]};
        bus64.pad_otpt_vld = 1'b1;
        bus64.pad_otpt_lst = lst && (k == nb - 1);
      end else begin
        bus32.pad_otpt_d   = b[k];
        bus32.pad_otpt_vld = 1'b1;
        bus32.pad_otpt_lst = lst && (k == nb - 1);
      end
      guard = 0;
      while (!(sel ? bus64.pad_otpt_ena : bus32.pad_otpt_ena) && guard < 300) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 300) chk("ena_wait", sel ? bus64.pad_otpt_ena : bus32.pad_otpt_ena, 1);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic latency(input bit sel);
    int lat;
    lat = 1;
    while (!(sel ? bus64.expnd_vld : bus32.expnd_vld) && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, EXP_LAT);
  endtask

  task automatic collect(input bit sel, input bit rnd, input bit exp_lst, input blk_t b,
                         input int stop_at, output wv_t o_wj, output wv_t o_wjj);
    wx_t e;
    int n, cyc;
    bit r, stalled;
    logic v, l, en;
    logic [31:0] wj, wjj, pw;
    expand(b, e);
    n = 0; cyc = 0; stalled = 0; pw = '0;
    for (int i = 0; i < 64; i++) begin o_wj[i] = '0; o_wjj[i] = '0; end
    while (n < stop_at && cyc < 2000) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus32.expnd_rdy = r;
      bus64.expnd_rdy = r;
      #1;
      v   = sel ? bus64.expnd_vld    : bus32.expnd_vld;
      l   = sel ? bus64.expnd_lst    : bus32.expnd_lst;
      en  = sel ? bus64.pad_otpt_ena : bus32.pad_otpt_ena;
      wj  = sel ? bus64.expnd_wj     : bus32.expnd_wj;
      wjj = sel ? bus64.expnd_wjj    : bus32.expnd_wjj;
      if (stalled) begin
        chk("stall_vld", v, 1);
        chk("stall_hold", wj, pw);
      end
      if (n < 63) chk("ena_low", en, 0);
      if (v && r) begin
        chk("wj", wj, e[n]);
        chk("wjj", wjj, e[n] ^ e[n+4]);
        chk("lst", l, exp_lst && (n == 63));
        o_wj[n] = wj; o_wjj[n] = wjj;
        n++;
      end else if (!v) begin
        chk("lst_idle", l, 0);
      end
      stalled = v && !r;
      pw = wj;
      @(posedge clk); #1;
      cyc++;
    end
    chk("hs_count", n, stop_at);
    bus32.expnd_rdy = 1'b1;
    bus64.expnd_rdy = 1'b1;
  endtask

  task automatic post_block(input bit sel);
    chk("ena_back", sel ? bus64.pad_otpt_ena : bus32.pad_otpt_ena, 1);
    chk("vld_done", sel ? bus64.expnd_vld : bus32.expnd_vld, 0);
  endtask

  task automatic run_block(input bit sel, input bit rnd, input bit lst, input blk_t b);
    send(sel, b, lst, sel ? 8 : 16);
    latency(sel);
    collect(sel, rnd, lst, b, 64, ow, owjj);
    post_block(sel);
  endtask

  task automatic chk_abc(input string tag);
    chk({tag, "_w0"},  ow[0],   32'h61626380);
    chk({tag, "_wj0"}, owjj[0], 32'h61626380);
    chk({tag, "_w16"}, ow[16],  32'h9092e200);
    chk({tag, "_w18"}, ow[18],  32'h000c0606);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc[i]  = '0;
      blk2[i] = 32'h9e3779b9 * 32'(i + 1);
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    idle_inputs();
    bus32.expnd_rdy = 1'b1;
    bus64.expnd_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_rst(0);
    chk_rst(1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(0, 0, 1, abc);
    chk_abc("abc32");

    run_block(1, 0, 1, abc);
    chk_abc("abc64");

    run_block(0, 0, 0, blk2);
    run_block(0, 0, 1, abc);
    chk_abc("b2b32");
    run_block(1, 0, 0, blk2);
    run_block(1, 0, 1, abc);

    run_block(0, 1, 1, abc);
    run_block(0, 1, 1, blk2);
    run_block(1, 1, 1, abc);
    run_block(1, 1, 0, blk2);

    send(0, abc, 1, 9);
    rst_n = 1'b0;
    #1;
    chk_rst(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(0, 0, 1, abc);
    chk_abc("rst_load");

    send(0, abc, 1, 16);
    latency(0);
    collect(0, 0, 1, abc, 30, ow, owjj);
    rst_n = 1'b0;
    #1;
    chk_rst(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(0, 0, 1, abc);
    chk_abc("rst_expnd");

    send(1, blk2, 1, 8);
    latency(1);
    collect(1, 1, 1, blk2, 30, ow, owjj);
    rst_n = 1'b0;
    #1;
    chk_rst(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block(1, 0, 1, abc);
    chk_abc("rst_expnd64");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
